cmd_frame_rx: RTL and testbench
===============================

# cmd_frame_rx

Host-to-FPGA command decoder for the sensor/AES capture platform. Sits between `uart_rx` (byte output) and the main capture FSM, on the UART clock domain. Decodes single-byte control commands (delay set, start) and checksummed 16-byte frames that load the AES key and plaintext. Replaces the hard-coded key and the chained plaintext with host-supplied values.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles allowed between bytes of a frame before it is aborted.
- `DELAY_RST`, default 15: reset value of `delay`.
- `clk` input 1: UART-domain clock. One clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx_dv` input 1: one-cycle strobe, `rx_byte` valid (from `uart_rx` `o_Rx_DV`).
- `rx_byte` input 8: received byte.
- `key` output 128: committed AES key, first received byte in [127:120].
- `key_vld` output 1: one-cycle pulse, `key` updated.
- `pt` output 128: committed plaintext, same byte order.
- `pt_vld` output 1: one-cycle pulse, `pt` updated.
- `delay` output 5: committed delay setting.
- `delay_vld` output 1: one-cycle pulse, `delay` updated.
- `start` output 1: one-cycle pulse, start one encryption/capture.
- `inc` output 1: qualifier of `start`; 1 = auto-increment delay. Held until the next `start`.
- `err` output 1: one-cycle pulse, frame or opcode error.
- `err_code` output 2: 1 = unknown opcode, 2 = checksum mismatch, 3 = timeout. Held until the next `err`.
- `busy` output 1: high while a frame is in progress.

## Operation
- Opcodes, accepted in IDLE only:
  - 0x00–0x1F: `delay` <= byte[4:0]; pulse `delay_vld`.
  - 0xFA: `start`, `inc`=1.
  - 0xF2: `start`, `inc`=0.
  - 0xF0: begin key frame.
  - 0xF1: begin plaintext frame.
  - Any other byte: `err`, code 1; stay IDLE.
- Frame format: opcode, then 16 payload bytes MSB-first, then 1 checksum byte equal to the XOR of the 16 payload bytes.
- States:
  - IDLE: decode opcode as above.
  - PAYLOAD: shift each byte into a 128-bit shadow register, XOR it into an 8-bit running checksum, count 0..15. On byte 15 go to CHKSUM.
  - CHKSUM: on `rx_dv`, compare the byte with the running checksum.
    - Match: copy the shadow register to `key` or `pt` (per latched opcode) and pulse `key_vld`/`pt_vld`.
    - Mismatch: `err`, code 2; committed output unchanged.
    - Either way, return to IDLE.
- Timeout: in PAYLOAD/CHKSUM, an idle counter clears on every `rx_dv` and increments otherwise. When it reaches `TIMEOUT_CYCLES`-1: `err`, code 3; discard the frame; return to IDLE.
- `busy` = (state != IDLE).
- `key`/`pt` change only on a successful commit. They are stable during a frame, so the consumer may sample them at any time.
- A 0x00–0x1F or 0xFA byte arriving inside a frame is payload data, not a command.

## Timing
- Every output is registered.
- Pulse outputs (`*_vld`, `start`, `err`) go high in the cycle after the `rx_dv` cycle that caused them and last exactly one cycle.
- The committed data value changes on that same edge.
- The FSM is back in IDLE in the cycle after the checksum byte, so a byte strobed in the next cycle is decoded as an opcode. No dead cycle.
- Timeout `err` fires exactly `TIMEOUT_CYCLES` cycles after the last accepted byte.
- `rx_dv` on the same cycle the timeout count is reached: the byte wins; the counter clears and no timeout occurs.
- Reset values:
  - `key`, `pt` = 0
  - `delay` = `DELAY_RST`
  - `inc` = 0
  - `err_code` = 0
  - all pulses = 0
  - `busy` = 0
  - state = IDLE; shadow register, checksum and counters = 0
- `rst` mid-frame: abort with no pulse; everything returns to reset values.
- Counter widths: payload index 4 bits; timeout counter `$clog2(TIMEOUT_CYCLES)` bits, saturating at terminal count.

## Structure
- Shared package `cmd_pkg` holds:
  - opcode constants: `CMD_START_INC`=8'hFA, `CMD_START`=8'hF2, `CMD_KEY`=8'hF0, `CMD_PT`=8'hF1, `CMD_DELAY_MAX`=8'h1F
  - state encoding: IDLE/PAYLOAD/CHKSUM
  - error codes `ERR_OPC`/`ERR_SUM`/`ERR_TMO`
  - `FRAME_BYTES`=16
- One sub-module is natural: `rx_timeout`. Ports: `clk`, `rst`, `clr`, `en`, `expired`. It is a parameterised idle counter, reusable for the UART transmit side later.

## Test plan
- Reset, then bytes 0x07 then 0xFA → `delay_vld` with `delay`=7; then `start` with `inc`=1. `busy` stays 0.
- 0xF0, bytes 0x00..0x0F, checksum 0x00 → one `key_vld`, `key`=128'h000102030405060708090A0B0C0D0E0F.
- 0xF1, 16×0xAA, checksum 0x01 (correct is 0x00) → `err`, `err_code`=2, no `pt_vld`, `pt` stays 0.
- 0xF1, 5 bytes, then silence with `TIMEOUT_CYCLES`=100 → `err`, code 3, exactly 100 cycles after the 5th byte. The next byte 0xF2 yields `start` with `inc`=0.
- 0x55 in IDLE → `err`, code 1. Key frame whose payload contains 0xFA bytes → no `start`; the key is committed.
- Assert `rst` after 8 payload bytes → no pulses; `busy`=0 next cycle. A following complete PT frame commits normally. Back-to-back frames with zero-gap `rx_dv` are all accepted.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared constants, state encoding and checksum helpers for the host command decoder.
package cmd_pkg;

  // Single-byte command opcodes (0x00..CMD_DELAY_MAX are delay settings)
  localparam logic [7:0] CMD_START_INC = 8'hFA;
  localparam logic [7:0] CMD_START     = 8'hF2;
  localparam logic [7:0] CMD_KEY       = 8'hF0;
  localparam logic [7:0] CMD_PT        = 8'hF1;
  localparam logic [7:0] CMD_DELAY_MAX = 8'h1F;

  // Payload length of a key / plaintext frame
  localparam int FRAME_BYTES = 16;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  // Error codes reported on err_code
  localparam logic [1:0] ERR_OPC = 2'd1;
  localparam logic [1:0] ERR_SUM = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHKSUM  = 2'd2
  } state_e;

  // Running frame checksum: plain XOR of every payload byte
  function automatic logic [7:0] sum_step(input logic [7:0] sum, input logic [7:0] b);
    return sum ^ b;
  endfunction

  // True for the bytes that set the delay directly
  function automatic logic is_delay_cmd(input logic [7:0] b);
    return (b <= CMD_DELAY_MAX);
  endfunction

endpackage

// File: rtl/rx_timeout.sv
// Idle-gap watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the terminal count is held. A clear in that same
// cycle wins, so a byte arriving just in time is never lost to a timeout.
module rx_timeout #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] TERM = W'(CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear on activity, otherwise count up and saturate at terminal
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TERM)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en & ~clr & (cnt_q == TERM);

endmodule

// File: rtl/cmd_frame_rx.sv
// Host command decoder: single-byte delay/start commands and XOR-checksummed
// 16-byte frames that load the AES key and plaintext. All outputs registered.
module cmd_frame_rx
  import cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [4:0] DELAY_RST      = 5'd15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_dv,
  input  logic [7:0]   rx_byte,
  output logic [127:0] key,
  output logic         key_vld,
  output logic [127:0] pt,
  output logic         pt_vld,
  output logic [4:0]   delay,
  output logic         delay_vld,
  output logic         start,
  output logic         inc,
  output logic         err,
  output logic [1:0]   err_code,
  output logic         busy
);

  state_e         state_q, state_d;
  logic [127:0]   shadow_q, shadow_d;
  logic [7:0]     sum_q, sum_d;
  logic [3:0]     idx_q, idx_d;
  logic           is_key_q, is_key_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   pt_q, pt_d;
  logic [4:0]     delay_q, delay_d;
  logic           inc_q, inc_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           key_vld_q, key_vld_d;
  logic           pt_vld_q, pt_vld_d;
  logic           delay_vld_q, delay_vld_d;
  logic           start_q, start_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;

  logic           tmo_clr_s;
  logic           tmo_en_s;
  logic           tmo_expired_s;

  // The watchdog only runs inside a frame; every strobed byte restarts it
  assign tmo_en_s  = (state_q != IDLE);
  assign tmo_clr_s = rx_dv | (state_q == IDLE);

  rx_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_rx_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr_s),
    .en      (tmo_en_s),
    .expired (tmo_expired_s)
  );

  // Next-state, frame datapath and output pulse decode
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    is_key_d    = is_key_q;
    key_d       = key_q;
    pt_d        = pt_q;
    delay_d     = delay_q;
    inc_d       = inc_q;
    err_code_d  = err_code_q;
    key_vld_d   = 1'b0;
    pt_vld_d    = 1'b0;
    delay_vld_d = 1'b0;
    start_d     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_dv) begin
          if (is_delay_cmd(rx_byte)) begin
            delay_d     = rx_byte[4:0];
            delay_vld_d = 1'b1;
          end else if (rx_byte == CMD_START_INC) begin
            start_d = 1'b1;
            inc_d   = 1'b1;
          end else if (rx_byte == CMD_START) begin
            start_d = 1'b1;
            inc_d   = 1'b0;
          end else if ((rx_byte == CMD_KEY) || (rx_byte == CMD_PT)) begin
            state_d  = PAYLOAD;
            is_key_d = (rx_byte == CMD_KEY);
            sum_d    = 8'h00;
            idx_d    = 4'd0;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_OPC;
          end
        end else begin
          state_d = IDLE;
        end
      end

      PAYLOAD: begin
        if (rx_dv) begin
          shadow_d = {shadow_q[119:0], rx_byte};
          sum_d    = sum_step(sum_q, rx_byte);
          idx_d    = idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_d = CHKSUM;
          end else begin
            state_d = PAYLOAD;
          end
        end else if (tmo_expired_s) begin
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
          state_d    = IDLE;
        end else begin
          state_d = PAYLOAD;
        end
      end

      CHKSUM: begin
        if (rx_dv) begin
          state_d = IDLE;
          if (rx_byte == sum_q) begin
            if (is_key_q) begin
              key_d     = shadow_q;
              key_vld_d = 1'b1;
            end else begin
              pt_d     = shadow_q;
              pt_vld_d = 1'b1;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_SUM;
          end
        end else if (tmo_expired_s) begin
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
          state_d    = IDLE;
        end else begin
          state_d = CHKSUM;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= 128'h0;
      sum_q       <= 8'h00;
      idx_q       <= 4'd0;
      is_key_q    <= 1'b0;
      key_q       <= 128'h0;
      pt_q        <= 128'h0;
      delay_q     <= DELAY_RST;
      inc_q       <= 1'b0;
      err_code_q  <= 2'd0;
      key_vld_q   <= 1'b0;
      pt_vld_q    <= 1'b0;
      delay_vld_q <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      is_key_q    <= is_key_d;
      key_q       <= key_d;
      pt_q        <= pt_d;
      delay_q     <= delay_d;
      inc_q       <= inc_d;
      err_code_q  <= err_code_d;
      key_vld_q   <= key_vld_d;
      pt_vld_q    <= pt_vld_d;
      delay_vld_q <= delay_vld_d;
      start_q     <= start_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign key       = key_q;
  assign key_vld   = key_vld_q;
  assign pt        = pt_q;
  assign pt_vld    = pt_vld_q;
  assign delay     = delay_q;
  assign delay_vld = delay_vld_q;
  assign start     = start_q;
  assign inc       = inc_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Directed bench for cmd_frame_rx with a short timeout (100 cycles).
module tb_cmd_frame_rx;

  localparam int TMO = 100;

  logic         clk;
  logic         rst;
  logic         rx_dv;
  logic [7:0]   rx_byte;
  logic [127:0] key;
  logic         key_vld;
  logic [127:0] pt;
  logic         pt_vld;
  logic [4:0]   delay;
  logic         delay_vld;
  logic         start;
  logic         inc;
  logic         err;
  logic [1:0]   err_code;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // pulse totals, sampled on every rising edge
  int n_key = 0, n_pt = 0, n_delay = 0, n_start = 0, n_err = 0;

  cmd_frame_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .key(key), .key_vld(key_vld), .pt(pt), .pt_vld(pt_vld),
    .delay(delay), .delay_vld(delay_vld), .start(start), .inc(inc),
    .err(err), .err_code(err_code), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // accumulate every pulse seen
  always @(posedge clk) begin
    n_key   += int'(key_vld);
    n_pt    += int'(pt_vld);
    n_delay += int'(delay_vld);
    n_start += int'(start);
    n_err   += int'(err);
  end

  // one byte strobe; returns 1 ns after the sampling edge
  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(posedge clk); #1;
    rx_dv   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_payload(input logic [127:0] p);
    for (int i = 0; i < 16; i++) send(p[127-8*i -: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
    idle(3);
    rst = 1'b0;
    idle(1);
    checks++; if (key !== 128'h0) begin errors++; $display("FAIL rst_key got %h exp 0", key); end
    checks++; if (pt !== 128'h0) begin errors++; $display("FAIL rst_pt got %h exp 0", pt); end
    checks++; if (delay !== 5'd15) begin errors++; $display("FAIL rst_delay got %0d exp 15", delay); end
    checks++; if ({inc, err_code, busy} !== 4'b0) begin errors++; $display("FAIL rst_inc_code_busy got %b exp 0000", {inc, err_code, busy}); end
    checks++; if ({key_vld, pt_vld, delay_vld, start, err} !== 5'b0) begin errors++; $display("FAIL rst_pulses got %b exp 00000", {key_vld, pt_vld, delay_vld, start, err}); end
  endtask

  task automatic test_delay_start();
    send(8'h07);
    checks++; if (delay_vld !== 1'b1 || delay !== 5'd7) begin errors++; $display("FAIL delay_set got vld=%b delay=%0d exp vld=1 delay=7", delay_vld, delay); end
    send(8'hFA);
    checks++; if (start !== 1'b1 || inc !== 1'b1 || delay_vld !== 1'b0) begin errors++; $display("FAIL start_inc got start=%b inc=%b dvld=%b exp 1 1 0", start, inc, delay_vld); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cmd_busy got %b exp 0", busy); end
    idle(1);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL start_width got %b exp 0", start); end
  endtask

  task automatic test_key_frame();
    int k0;
    k0 = n_key;
    send(8'hF0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy got %b exp 1", busy); end
    send_payload(128'h000102030405060708090A0B0C0D0E0F);
    checks++; if (key !== 128'h0) begin errors++; $display("FAIL key_stable got %h exp 0", key); end
    send(8'h00);
    checks++; if (key_vld !== 1'b1 || key !== 128'h000102030405060708090A0B0C0D0E0F) begin errors++; $display("FAIL key_commit got vld=%b key=%h", key_vld, key); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL key_busy_end got %b exp 0", busy); end
    idle(2);
    checks++; if (n_key - k0 !== 1) begin errors++; $display("FAIL key_vld_count got %0d exp 1", n_key - k0); end
  endtask

  task automatic test_bad_checksum();
    int p0;
    p0 = n_pt;
    send(8'hF1);
    send_payload({16{8'hAA}});
    send(8'h01);
    checks++; if (err !== 1'b1 || err_code !== 2'd2) begin errors++; $display("FAIL sum_err got err=%b code=%0d exp 1 2", err, err_code); end
    idle(2);
    checks++; if (n_pt - p0 !== 0 || pt !== 128'h0) begin errors++; $display("FAIL sum_no_commit got n=%0d pt=%h exp 0 0", n_pt - p0, pt); end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    send(8'hF1);
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i));
    for (int k = 1; k <= TMO; k++) begin
      idle(1);
      if (k < TMO && err === 1'b1) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL tmo_early got %0d early err cycles exp 0", early); end
    checks++; if (err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin errors++; $display("FAIL tmo_fire got err=%b code=%0d busy=%b exp 1 3 0", err, err_code, busy); end
    send(8'hF2);
    checks++; if (start !== 1'b1 || inc !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL tmo_then_start got start=%b inc=%b err=%b exp 1 0 0", start, inc, err); end
  endtask

  task automatic test_bad_opcode();
    send(8'h55);
    checks++; if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin errors++; $display("FAIL opc_err got err=%b code=%0d busy=%b exp 1 1 0", err, err_code, busy); end
  endtask

  task automatic test_payload_cmds();
    int s0, d0;
    s0 = n_start; d0 = n_delay;
    send(8'hF0);
    send_payload({8{8'hFA, 8'h05}});
    send(8'h00);
    checks++; if (key_vld !== 1'b1 || key !== {8{8'hFA, 8'h05}}) begin errors++; $display("FAIL fa_key got vld=%b key=%h", key_vld, key); end
    idle(1);
    checks++; if (n_start - s0 !== 0 || n_delay - d0 !== 0 || delay !== 5'd7) begin errors++; $display("FAIL payload_as_cmd got starts=%0d delays=%0d delay=%0d exp 0 0 7", n_start - s0, n_delay - d0, delay); end
  endtask

  task automatic test_rst_mid_frame();
    int tot0;
    send(8'hF1);
    for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i));
    tot0 = n_key + n_pt + n_delay + n_start + n_err;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || key !== 128'h0 || delay !== 5'd15) begin errors++; $display("FAIL rst_mid got busy=%b key=%h delay=%0d exp 0 0 15", busy, key, delay); end
    idle(2);
    checks++; if (n_key + n_pt + n_delay + n_start + n_err - tot0 !== 0) begin errors++; $display("FAIL rst_mid_pulses got %0d exp 0", n_key + n_pt + n_delay + n_start + n_err - tot0); end
    send(8'hF1);
    send_payload(128'h101112131415161718191A1B1C1D1E1F);
    send(8'h00);
    checks++; if (pt_vld !== 1'b1 || pt !== 128'h101112131415161718191A1B1C1D1E1F) begin errors++; $display("FAIL pt_after_rst got vld=%b pt=%h", pt_vld, pt); end
  endtask

  task automatic test_back_to_back();
    send(8'hF0);
    send_payload(128'h808182838485868788898A8B8C8D8E8F);
    send(8'h00);
    checks++; if (key_vld !== 1'b1 || key !== 128'h808182838485868788898A8B8C8D8E8F) begin errors++; $display("FAIL b2b_key got vld=%b key=%h", key_vld, key); end
    send(8'hF1);
    send_payload(128'h01000000000000000000000000000000);
    send(8'h01);
    checks++; if (pt_vld !== 1'b1 || pt !== 128'h01000000000000000000000000000000) begin errors++; $display("FAIL b2b_pt got vld=%b pt=%h", pt_vld, pt); end
    send(8'h03);
    checks++; if (delay_vld !== 1'b1 || delay !== 5'd3 || busy !== 1'b0) begin errors++; $display("FAIL b2b_delay got vld=%b delay=%0d busy=%b exp 1 3 0", delay_vld, delay, busy); end
  endtask

  initial begin
    test_reset();
    test_delay_start();
    test_key_frame();
    test_bad_checksum();
    test_timeout();
    test_bad_opcode();
    test_payload_cmds();
    test_rst_mid_frame();
    test_back_to_back();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
